// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch stage.
package fetch_pkg;

    localparam int unsigned PC_W   = 36;
    localparam int unsigned INST_W = 32;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   pc_plus_4;
    } fq_entry_t;

    function automatic logic [PC_W-1:0] pc_inc4(input logic [PC_W-1:0] pc);
        return pc + PC_W'(4);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO with flush; holds fetched entries or in-flight PC tags.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter type         T     = fq_entry_t
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  T                           wr_data,
    output T                           rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH+1);

    T              mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count < CW'(DEPTH)) || do_pop);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the fetch PC, issues in-order imem requests with
// credit-based flow control, and queues returned words for decode.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [35:0] RESET_PC = 36'h0,
    parameter int unsigned QDEPTH   = 2,
    parameter int unsigned MAX_OUT  = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [35:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [35:0] redirect_pc,
    input  logic        dec_ready,
    output logic        dec_valid,
    output logic [31:0] inst,
    output logic [35:0] pc_plus_4
);

    localparam int unsigned OW  = $clog2(MAX_OUT+1);
    localparam int unsigned QW  = $clog2(QDEPTH+1);
    localparam int unsigned CUW = QW + OW + 1;

    logic [PC_W-1:0] fetch_pc;
    logic [OW-1:0]   outstanding;
    logic [OW-1:0]   drop_cnt;
    logic [QW-1:0]   q_count;
    logic [OW-1:0]   tag_count;
    logic [PC_W-1:0] tag_head;
    logic [CUW-1:0]  credit_used;
    fq_entry_t       q_wr;
    fq_entry_t       q_head;
    logic            req_fire;
    logic            resp_ok;
    logic            push_q;
    logic            pop_q;

    // Slots already claimed: queued words plus live (non-dropped) requests.
    assign credit_used = CUW'(q_count) + CUW'(outstanding) - CUW'(drop_cnt);

    assign imem_req_valid = !rst && !redirect_valid
                          && (outstanding < OW'(MAX_OUT))
                          && (credit_used < CUW'(QDEPTH));
    assign imem_req_addr  = fetch_pc;

    assign req_fire  = imem_req_valid && imem_req_ready;
    assign resp_ok   = imem_resp_valid && (outstanding != '0);
    assign dec_valid = (q_count != '0);
    assign pop_q     = dec_valid && dec_ready;
    assign push_q    = resp_ok && (drop_cnt == '0) && !redirect_valid;
    assign q_wr      = '{inst: imem_resp_data, pc_plus_4: tag_head};
    assign inst      = q_head.inst;
    assign pc_plus_4 = q_head.pc_plus_4;

    // Tags ride alongside requests so every response, kept or dropped, retires one.
    fetch_queue #(
        .DEPTH (MAX_OUT),
        .T     (logic [PC_W-1:0])
    ) u_tag_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (req_fire),
        .pop     (resp_ok),
        .flush   (1'b0),
        .wr_data (pc_inc4(fetch_pc)),
        .rd_data (tag_head),
        .count   (tag_count)
    );

    fetch_queue #(
        .DEPTH (QDEPTH),
        .T     (fq_entry_t)
    ) u_inst_q (
        .clk     (clk),
        .rst     (rst),
        .push    (push_q),
        .pop     (pop_q),
        .flush   (redirect_valid),
        .wr_data (q_wr),
        .rd_data (q_head),
        .count   (q_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding + OW'(req_fire) - OW'(resp_ok);
            if (redirect_valid) begin
                fetch_pc <= redirect_pc & {{(PC_W-2){1'b1}}, 2'b00};
                drop_cnt <= outstanding - OW'(resp_ok);
            end else begin
                if (req_fire) begin
                    fetch_pc <= pc_inc4(fetch_pc);
                end
                if (resp_ok && (drop_cnt != '0)) begin
                    drop_cnt <= drop_cnt - OW'(1);
                end
            end
            assert (!(imem_resp_valid && (outstanding == '0)));
            assert (tag_count == outstanding);
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with an in-order memory responder and a
// scoreboard of expected {inst, pc_plus_4} pushed at request accept.
module tb_fetch_stage;
    import fetch_pkg::*;

    localparam logic [35:0] RPC = 36'h100;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [35:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data  = '0;
    logic        redirect_valid;
    logic [35:0] redirect_pc;
    logic        dec_ready;
    logic        dec_valid;
    logic [31:0] inst;
    logic [35:0] pc_plus_4;

    logic        resp_en;
    logic        stray;
    logic [35:0] exp_addr;
    fq_entry_t   sb[$];
    logic [35:0] pend[$];
    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    always #5 clk = ~clk;

    fetch_stage #(
        .RESET_PC (RPC),
        .QDEPTH   (2),
        .MAX_OUT  (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .dec_ready       (dec_ready),
        .dec_valid       (dec_valid),
        .inst            (inst),
        .pc_plus_4       (pc_plus_4)
    );

    function automatic logic [31:0] mem_word(input logic [35:0] a);
        return a[33:2] ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_valid"}, 64'(imem_req_valid), 64'd0);
        check({tag, "_dec_valid"}, 64'(dec_valid), 64'd0);
        check({tag, "_inst"}, 64'(inst), 64'd0);
        check({tag, "_pc_plus_4"}, 64'(pc_plus_4), 64'd0);
        check({tag, "_req_addr"}, 64'(imem_req_addr), 64'(RPC));
    endtask

    // Memory: answers accepted requests in order, one cycle later at the earliest.
    always @(negedge clk) begin
        if (rst) begin
            pend.delete();
            imem_resp_valid = stray;
            imem_resp_data  = 32'hDEAD_BEEF;
        end else begin
            imem_resp_valid = 1'b0;
            if (resp_en && (pend.size() != 0)) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = mem_word(pend.pop_front());
            end
            if (imem_req_valid && imem_req_ready) begin
                pend.push_back(imem_req_addr);
            end
        end
    end

    // Reference fetch PC and scoreboard; a redirect drops everything not yet popped.
    always @(negedge clk) begin
        fq_entry_t e;
        if (rst) begin
            sb.delete();
            exp_addr = RPC;
        end else begin
            check("req_addr", 64'(imem_req_addr), 64'(exp_addr));
            if (dec_valid && dec_ready) begin
                if (sb.size() != 0) e = sb.pop_front();
                else                e = '1;
                check("dec_inst", 64'(inst), 64'(e.inst));
                check("dec_pc_plus_4", 64'(pc_plus_4), 64'(e.pc_plus_4));
            end
            if (redirect_valid) begin
                sb.delete();
                exp_addr = redirect_pc & ~36'h3;
            end else if (imem_req_valid && imem_req_ready) begin
                e.inst      = mem_word(exp_addr);
                e.pc_plus_4 = exp_addr + 36'd4;
                sb.push_back(e);
                exp_addr = exp_addr + 36'd4;
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int unsigned cnt;
        int unsigned n;

        imem_req_ready = 1'b1;
        dec_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        resp_en        = 1'b1;
        stray          = 1'b0;
        #1 rst = 1'b1;
        #2;
        check_reset_outputs("reset");

        // A stray response while held in reset must leave no trace.
        stray = 1'b1;
        neg();
        stray = 1'b0;
        cyc();
        rst = 1'b0;

        // Startup stream from RESET_PC.
        neg();
        check("first_req_valid", 64'(imem_req_valid), 64'd1);
        neg();
        check("fill_dec_valid", 64'(dec_valid), 64'd0);
        neg();
        check("first_dec_valid", 64'(dec_valid), 64'd1);
        check("first_pc_plus_4", 64'(pc_plus_4), 64'h104);
        cnt = 1;
        repeat (8) begin
            neg();
            cnt += int'(dec_valid);
        end
        check("stream_occupancy", 64'(cnt), 64'd6);

        // Decode backpressure.
        cyc();
        dec_ready = 1'b0;
        repeat (10) neg();
        check("bp_req_valid", 64'(imem_req_valid), 64'd0);
        check("bp_dec_valid", 64'(dec_valid), 64'd1);
        cyc();
        dec_ready = 1'b1;
        repeat (10) neg();

        // Memory not ready: request held.
        cyc();
        imem_req_ready = 1'b0;
        repeat (3) neg();
        repeat (5) begin
            neg();
            check("stall_req_valid", 64'(imem_req_valid), 64'd1);
        end
        cyc();
        imem_req_ready = 1'b1;
        repeat (6) neg();

        // Redirect with two requests in flight.
        cyc();
        resp_en = 1'b0;
        n = 0;
        do begin
            neg();
            n++;
        end while (!(imem_req_valid == 1'b0 && dec_valid == 1'b0) && n < 20);
        check("two_outstanding", 64'({imem_req_valid, dec_valid}), 64'd0);
        cyc();
        redirect_valid = 1'b1;
        redirect_pc    = 36'h2003;
        resp_en        = 1'b1;
        neg();
        check("redir_no_issue", 64'(imem_req_valid), 64'd0);
        cyc();
        redirect_valid = 1'b0;
        neg();
        check("redir_req_valid", 64'(imem_req_valid), 64'd1);
        check("redir_req_addr", 64'(imem_req_addr), 64'h2000);
        check("redir_flushed", 64'(dec_valid), 64'd0);
        neg();
        check("redir_wait", 64'(dec_valid), 64'd0);
        neg();
        check("redir_dec_valid", 64'(dec_valid), 64'd1);
        check("redir_pc_plus_4", 64'(pc_plus_4), 64'h2004);

        // Redirect coinciding with a pop and a response.
        n = 0;
        do begin
            neg();
            n++;
        end while (!(dec_valid == 1'b0 && imem_resp_valid == 1'b1) && n < 20);
        check("pre_redir_state", 64'({dec_valid, imem_resp_valid}), 64'd1);
        cyc();
        redirect_valid = 1'b1;
        redirect_pc    = 36'h3000;
        neg();
        check("same_cycle_setup", 64'({dec_valid, imem_resp_valid}), 64'd3);
        cyc();
        redirect_valid = 1'b0;
        neg();
        check("sc_req_addr", 64'(imem_req_addr), 64'h3000);
        check("sc_flushed", 64'(dec_valid), 64'd0);
        neg();
        check("sc_wait", 64'(dec_valid), 64'd0);
        neg();
        check("sc_dec_valid", 64'(dec_valid), 64'd1);
        check("sc_pc_plus_4", 64'(pc_plus_4), 64'h3004);

        // PC wrap at the top of the address space.
        cyc();
        redirect_valid = 1'b1;
        redirect_pc    = 36'hF_FFFF_FFFC;
        cyc();
        redirect_valid = 1'b0;
        neg();
        check("wrap_req_addr_top", 64'(imem_req_addr), 64'hF_FFFF_FFFC);
        neg();
        check("wrap_req_addr_zero", 64'(imem_req_addr), 64'h0);
        n = 0;
        while (!dec_valid && n < 10) begin
            neg();
            n++;
        end
        check("wrap_pc_plus_4", 64'(pc_plus_4), 64'h0);
        repeat (8) neg();

        // Asynchronous reset with two requests in flight.
        cyc();
        resp_en = 1'b0;
        n = 0;
        do begin
            neg();
            n++;
        end while (!(imem_req_valid == 1'b0 && dec_valid == 1'b0) && n < 20);
        check("rst_two_outstanding", 64'({imem_req_valid, dec_valid}), 64'd0);
        cyc();
        rst     = 1'b1;
        stray   = 1'b1;
        resp_en = 1'b1;
        #1;
        check_reset_outputs("midrst");
        neg();
        neg();
        cyc();
        stray          = 1'b0;
        imem_req_ready = 1'b0;
        rst            = 1'b0;
        repeat (3) begin
            neg();
            check("post_rst_dec_valid", 64'(dec_valid), 64'd0);
            check("post_rst_req_valid", 64'(imem_req_valid), 64'd1);
        end
        cyc();
        imem_req_ready = 1'b1;
        neg();
        neg();
        neg();
        check("restart_dec_valid", 64'(dec_valid), 64'd1);
        check("restart_pc_plus_4", 64'(pc_plus_4), 64'h104);
        repeat (6) neg();

        // Stop issuing and let everything drain: nothing may be left unseen.
        cyc();
        imem_req_ready = 1'b0;
        repeat (6) neg();
        check("sb_drained", 64'(sb.size()), 64'd0);
        check("final_dec_valid", 64'(dec_valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
